// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the PS/2 to ZX Spectrum keyboard matrix:
// parser states, PS/2 prefix bytes and the logical key slot names.
package zx_kbd_pkg;

    localparam int KIDX_W   = 6;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 5;

    localparam logic [7:0] PS2_E0     = 8'hE0;
    localparam logic [7:0] PS2_E1     = 8'hE1;
    localparam logic [7:0] PS2_F0     = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } parse_state_e;

    // Logical key slots; row-ordered direct keys first, composites after.
    typedef enum logic [KIDX_W-1:0] {
        SLOT_CS_L, SLOT_CS_R, SLOT_Z, SLOT_X, SLOT_C, SLOT_V,
        SLOT_A, SLOT_S, SLOT_D, SLOT_F, SLOT_G,
        SLOT_Q, SLOT_W, SLOT_E, SLOT_R, SLOT_T,
        SLOT_1, SLOT_2, SLOT_3, SLOT_4, SLOT_5,
        SLOT_0, SLOT_9, SLOT_8, SLOT_7, SLOT_6,
        SLOT_P, SLOT_O, SLOT_I, SLOT_U, SLOT_Y,
        SLOT_ENTER, SLOT_L, SLOT_K, SLOT_J, SLOT_H,
        SLOT_SPACE, SLOT_SS_L, SLOT_SS_R, SLOT_M, SLOT_N, SLOT_B,
        SLOT_COMMA, SLOT_PERIOD, SLOT_SLASH, SLOT_SEMI, SLOT_QUOTE,
        SLOT_MINUS, SLOT_EQUAL, SLOT_BKSP,
        SLOT_LEFT, SLOT_DOWN, SLOT_UP, SLOT_RIGHT, SLOT_KP_ENTER
    } slot_e;

    localparam int NUM_SLOTS = 55;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic [7:0] code;
        logic [2:0] row0;
        logic [2:0] col0;
        logic       dual;
        logic [2:0] row1;
        logic [2:0] col1;
    } key_def_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
               (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/zx_keymap.sv
// Combinational key map: {ext, code} -> {hit, idx}, and per-slot matrix masks.
// This is the only place the ZX 8x5 layout and PS/2 set-2 codes live.
module zx_keymap
    import zx_kbd_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 5,
    parameter int NKEYS = 64
) (
    input  logic                   ext,
    input  logic [7:0]             code,
    output logic                   hit,
    output logic [KIDX_W-1:0]      idx,
    output logic [ROWS*COLS-1:0]   masks [NKEYS]
);

    localparam int CELLS = ROWS * COLS;

    function automatic key_def_t direct(input logic e, input logic [7:0] c,
                                        input int r, input int k);
        key_def_t d;
        d       = '0;
        d.valid = 1'b1;
        d.ext   = e;
        d.code  = c;
        d.row0  = 3'(r);
        d.col0  = 3'(k);
        return d;
    endfunction

    function automatic key_def_t combo(input logic e, input logic [7:0] c,
                                       input int r0, input int k0,
                                       input int r1, input int k1);
        key_def_t d;
        d      = direct(e, c, r0, k0);
        d.dual = 1'b1;
        d.row1 = 3'(r1);
        d.col1 = 3'(k1);
        return d;
    endfunction

    // Row 0 = CS Z X C V ... row 7 = Space SS M N B; composites add CS (0,0) or SS (7,1).
    function automatic key_def_t slot_def(input logic [KIDX_W-1:0] s);
        key_def_t d;
        d = '0;
        case (s)
            SLOT_CS_L:     d = direct(1'b0, 8'h12, 0, 0);
            SLOT_CS_R:     d = direct(1'b0, 8'h59, 0, 0);
            SLOT_Z:        d = direct(1'b0, 8'h1A, 0, 1);
            SLOT_X:        d = direct(1'b0, 8'h22, 0, 2);
            SLOT_C:        d = direct(1'b0, 8'h21, 0, 3);
            SLOT_V:        d = direct(1'b0, 8'h2A, 0, 4);
            SLOT_A:        d = direct(1'b0, 8'h1C, 1, 0);
            SLOT_S:        d = direct(1'b0, 8'h1B, 1, 1);
            SLOT_D:        d = direct(1'b0, 8'h23, 1, 2);
            SLOT_F:        d = direct(1'b0, 8'h2B, 1, 3);
            SLOT_G:        d = direct(1'b0, 8'h34, 1, 4);
            SLOT_Q:        d = direct(1'b0, 8'h15, 2, 0);
            SLOT_W:        d = direct(1'b0, 8'h1D, 2, 1);
            SLOT_E:        d = direct(1'b0, 8'h24, 2, 2);
            SLOT_R:        d = direct(1'b0, 8'h2D, 2, 3);
            SLOT_T:        d = direct(1'b0, 8'h2C, 2, 4);
            SLOT_1:        d = direct(1'b0, 8'h16, 3, 0);
            SLOT_2:        d = direct(1'b0, 8'h1E, 3, 1);
            SLOT_3:        d = direct(1'b0, 8'h26, 3, 2);
            SLOT_4:        d = direct(1'b0, 8'h25, 3, 3);
            SLOT_5:        d = direct(1'b0, 8'h2E, 3, 4);
            SLOT_0:        d = direct(1'b0, 8'h45, 4, 0);
            SLOT_9:        d = direct(1'b0, 8'h46, 4, 1);
            SLOT_8:        d = direct(1'b0, 8'h3E, 4, 2);
            SLOT_7:        d = direct(1'b0, 8'h3D, 4, 3);
            SLOT_6:        d = direct(1'b0, 8'h36, 4, 4);
            SLOT_P:        d = direct(1'b0, 8'h4D, 5, 0);
            SLOT_O:        d = direct(1'b0, 8'h44, 5, 1);
            SLOT_I:        d = direct(1'b0, 8'h43, 5, 2);
            SLOT_U:        d = direct(1'b0, 8'h3C, 5, 3);
            SLOT_Y:        d = direct(1'b0, 8'h35, 5, 4);
            SLOT_ENTER:    d = direct(1'b0, 8'h5A, 6, 0);
            SLOT_L:        d = direct(1'b0, 8'h4B, 6, 1);
            SLOT_K:        d = direct(1'b0, 8'h42, 6, 2);
            SLOT_J:        d = direct(1'b0, 8'h3B, 6, 3);
            SLOT_H:        d = direct(1'b0, 8'h33, 6, 4);
            SLOT_SPACE:    d = direct(1'b0, 8'h29, 7, 0);
            SLOT_SS_L:     d = direct(1'b0, 8'h14, 7, 1);
            SLOT_SS_R:     d = direct(1'b1, 8'h14, 7, 1);
            SLOT_M:        d = direct(1'b0, 8'h3A, 7, 2);
            SLOT_N:        d = direct(1'b0, 8'h31, 7, 3);
            SLOT_B:        d = direct(1'b0, 8'h32, 7, 4);
            SLOT_COMMA:    d = combo(1'b0, 8'h41, 7, 1, 7, 3);
            SLOT_PERIOD:   d = combo(1'b0, 8'h49, 7, 1, 7, 2);
            SLOT_SLASH:    d = combo(1'b0, 8'h4A, 7, 1, 0, 4);
            SLOT_SEMI:     d = combo(1'b0, 8'h4C, 7, 1, 5, 1);
            SLOT_QUOTE:    d = combo(1'b0, 8'h52, 7, 1, 4, 3);
            SLOT_MINUS:    d = combo(1'b0, 8'h4E, 7, 1, 6, 3);
            SLOT_EQUAL:    d = combo(1'b0, 8'h55, 7, 1, 6, 1);
            SLOT_BKSP:     d = combo(1'b0, 8'h66, 0, 0, 4, 0);
            SLOT_LEFT:     d = combo(1'b1, 8'h6B, 0, 0, 3, 4);
            SLOT_DOWN:     d = combo(1'b1, 8'h72, 0, 0, 4, 4);
            SLOT_UP:       d = combo(1'b1, 8'h75, 0, 0, 4, 3);
            SLOT_RIGHT:    d = combo(1'b1, 8'h74, 0, 0, 4, 2);
            SLOT_KP_ENTER: d = direct(1'b1, 8'h5A, 6, 0);
            default:       d = '0;
        endcase
        return d;
    endfunction

    // Cells outside a reduced geometry are simply dropped.
    function automatic logic [CELLS-1:0] slot_mask(input key_def_t d);
        logic [CELLS-1:0] m;
        m = '0;
        if (d.valid) begin
            if (int'(d.row0) < ROWS && int'(d.col0) < COLS)
                m = m | (CELLS'(1) << (int'(d.row0) * COLS + int'(d.col0)));
            if (d.dual && int'(d.row1) < ROWS && int'(d.col1) < COLS)
                m = m | (CELLS'(1) << (int'(d.row1) * COLS + int'(d.col1)));
        end
        return m;
    endfunction

    logic [NKEYS-1:0]  match;
    logic [KIDX_W-1:0] idx_chain [NKEYS+1];

    assign idx_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_slot
            key_def_t def;
            assign def      = slot_def(KIDX_W'(gi));
            assign match[gi] = def.valid && (def.ext == ext) && (def.code == code);
            assign masks[gi] = slot_mask(def);
            // Codes are unique per slot, so OR-ing matched indices is an encoder.
            assign idx_chain[gi+1] = idx_chain[gi] | (match[gi] ? KIDX_W'(gi) : '0);
        end
    endgenerate

    assign hit = |match;
    assign idx = idx_chain[NKEYS];

endmodule

// File: rtl/zx_kbd_matrix.sv
// PS/2 scan-code parser feeding a per-key pressed vector and a registered
// active-high ZX matrix; columns are reduced combinationally against row_sel.
module zx_kbd_matrix
    import zx_kbd_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int NKEYS   = 64,
    parameter int E1_SKIP = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      ps2_data,
    input  logic            ps2_valid,
    input  logic            clear,
    input  logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_out,
    output logic            any_key
);

    localparam int CELLS = ROWS * COLS;
    localparam int CNT_W = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

    parse_state_e      state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ev_valid, ev_make, ev_ext;
    logic              hit;
    logic [KIDX_W-1:0] idx;
    logic [CELLS-1:0]  masks [NKEYS];
    logic [NKEYS-1:0]  pressed;
    logic [CELLS-1:0]  or_chain [NKEYS+1];
    logic [CELLS-1:0]  matrix_reg;
    logic              any_key_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ev_valid   = 1'b0;
        ev_make    = 1'b0;
        ev_ext     = 1'b0;
        if (ps2_valid) begin
            case (state_reg)
                ST_IDLE: begin
                    if (ps2_data == PS2_E0) begin
                        state_next = ST_EXT;
                    end else if (ps2_data == PS2_F0) begin
                        state_next = ST_BRK;
                    end else if (ps2_data == PS2_E1) begin
                        if (E1_SKIP > 0) begin
                            state_next = ST_SKIP;
                            cnt_next   = CNT_W'(E1_SKIP);
                        end
                    end else if (!is_ignored(ps2_data)) begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_data == PS2_F0) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        // E0 12 / E0 59 are the fake shifts sent around nav keys.
                        state_next = ST_IDLE;
                        if (ps2_data != PS2_LSHIFT && ps2_data != PS2_RSHIFT) begin
                            ev_valid = 1'b1;
                            ev_make  = 1'b1;
                            ev_ext   = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    ev_valid   = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    ev_valid   = 1'b1;
                    ev_ext     = 1'b1;
                end
                ST_SKIP: begin
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    zx_keymap #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .NKEYS (NKEYS)
    ) u_keymap (
        .ext   (ev_ext),
        .code  (ps2_data),
        .hit   (hit),
        .idx   (idx),
        .masks (masks)
    );

    assign or_chain[0] = '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            logic slot_reg;
            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    slot_reg <= 1'b0;
                end else if (ev_valid && hit && idx == KIDX_W'(gi)) begin
                    slot_reg <= ev_make;
                end
            end
            assign pressed[gi]    = slot_reg;
            assign or_chain[gi+1] = or_chain[gi] | (slot_reg ? masks[gi] : '0);
        end
    endgenerate

    // One slot per physical key, so a shared cell stays set while any owner is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            matrix_reg  <= '0;
            any_key_reg <= 1'b0;
        end else begin
            matrix_reg  <= or_chain[NKEYS];
            any_key_reg <= |pressed;
        end
    end

    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [ROWS-1:0] col_bits;
            for (gj = 0; gj < ROWS; gj++) begin : g_row
                assign col_bits[gj] = matrix_reg[gj*COLS + gi];
            end
            assign col_out[gi] = ~|(col_bits & ~row_sel);
        end
    endgenerate

    assign any_key = any_key_reg;

endmodule

// File: doc/zx_kbd_matrix.md
# zx_kbd_matrix

Parametrised PS/2-to-ZX-Spectrum keyboard matrix. Consumes decoded PS/2 scan-code bytes, tracks every physical key independently (including `E0`-extended keys), and presents an N-row × M-column active-low matrix to the Z80 port `FE` read path. It replaces the inline scan-code case in the top level and fixes shared-key release: releasing `,` no longer drops Symbol Shift while Right-Ctrl is still held.

## Interface
- `ROWS`, 8: matrix rows, selected by address bits A8.. of the port read.
- `COLS`, 5: matrix columns, i.e. data bits D0...
- `NKEYS`, 64: logical key slots tracked; must be ≤ 2^`KIDX_W`.
- `E1_SKIP`, 7: bytes discarded after an `E1` (Pause) prefix.
- `clk`  in  1  system clock, `CLOCK_50` domain.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ps2_data`  in  8  received scan-code byte.
- `ps2_valid`  in  1  one-cycle strobe; `ps2_data` is valid only in that cycle.
- `clear`  in  1  synchronous force-release of all keys; parser state kept.
- `row_sel`  in  `ROWS`  active-low row select (Z80 A15..A8 for the default).
- `col_out`  out  `COLS`  active-low column data, combinational from `row_sel` and the matrix register.
- `any_key`  out  1  high when any logical key is pressed.

## Operation
- Parser FSM states: `IDLE`, `EXT` (after `E0`), `BRK` (after `F0`), `EXT_BRK` (after `E0 F0`), `SKIP`.
- Transitions run only on `ps2_valid`:
  - `IDLE`: `E0` → `EXT`; `F0` → `BRK`; `E1` → `SKIP` with counter = `E1_SKIP`; `AA`/`FA`/`FE`/`00`/`FF` are ignored and the FSM stays in `IDLE`; any other byte is a make of (ext=0, code).
  - `EXT`: `F0` → `EXT_BRK`; `12` or `59` (fake shifts) → `IDLE`, ignored; any other byte is a make of (ext=1, code) → `IDLE`.
  - `BRK`: break of (0, code) → `IDLE`.
  - `EXT_BRK`: break of (1, code) → `IDLE`.
  - `SKIP`: decrement the counter; go to `IDLE` when it reaches 0.
- Make/break drives lookup `{ext, code}` → `{hit, idx}`. A hit sets or clears `pressed[idx]`. A miss is ignored.
- Each slot idx has a constant mask of `ROWS*COLS` bits; bit r*COLS+c means row r, column c.
- Matrix register: `matrix <= OR over idx of (pressed[idx] ? mask[idx] : 0)`, active-high internally.
- Outputs:
  - `col_out[c] = ~|(matrix[r*COLS+c] & ~row_sel[r])` over all r.
  - `any_key = |pressed`.
- Mandatory map, default geometry:
  - The 40 direct keys: rows 0..7 in ZX order. Row 0 = CS Z X C V, where CS is L-Shift `12` and R-Shift `59`. Row 7 = Space, SS, M, N, B, where SS is L-Ctrl `14` and R-Ctrl `E0 14`.
  - Composites:
    - `, . / ; ' - =` → SS + N/M/V/O/7/J/L.
    - Backspace `66` → CS+0.
    - Arrows `E0 6B/72/75/74` → CS + 5/6/7/8.
    - Keypad Enter `E0 5A` → Enter.
- `clear` zeroes `pressed` in the cycle it is sampled. If `clear` and a make arrive together, `clear` wins.

## Timing
- Reset values: FSM `IDLE`, counter 0, `pressed` 0, `matrix` 0, `col_out` all ones, `any_key` 0.
- A byte strobed at edge N updates `pressed` at edge N. `matrix` and `any_key` follow at edge N+1. `col_out` is valid after N+1 with zero added latency from `row_sel`.
- Back-to-back strobes on consecutive cycles are accepted. No backpressure.
- A repeated make of a held key is idempotent. A break of a non-held key is a no-op.
- `reset` mid-sequence (e.g. after `E0` or in `SKIP`) returns to `IDLE`. The next byte is parsed fresh.
- Shared bits stay asserted while any slot that maps to them is pressed.

## Structure
- Package `zx_kbd_pkg`: FSM state enum, `KIDX_W`, prefix constants (`E0`, `E1`, `F0`, ignored codes), and the slot index names.
- Sub-module `zx_keymap`: purely combinational. Maps `{ext, code}` to `{hit, idx}`, and idx to the mask. It is the only place the default geometry is hard-coded.
- Top: FSM, skip counter, `pressed` vector, matrix register, column reduce.

## Test plan
- Reset, then `row_sel=8'hFE` → `col_out=5'h1F`, `any_key=0`. Send `1A` → after 2 cycles `col_out=5'h1D`.
- Press `41` (`,`) and `14` (L-Ctrl), then `F0 41`; `row_sel=8'h7F` → `col_out=5'h1D`: SS held, N released.
- Send `E0 75` (Up) → `row_sel=8'hFE` gives `5'h1E` and `row_sel=8'hEF` gives `5'h17`. Then `E0 F0 75` → both read `5'h1F`.
- Send the Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `1C` → only A is pressed; `row_sel=8'hFD` gives `5'h1E`.
- Send `E0`, assert `reset`, then send `74` → no key pressed (plain `74` is unmapped); `any_key=0`.
- Hold `16`, `1E` and `2E` together, with `row_sel=8'h00` → `5'h0C`. Assert `clear` → `5'h1F` and `any_key=0` two cycles later.
